// File: rtl/f_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : f_pc_ctrl
//  Purpose  : Fetch-stage PC owner for the 5-stage MIPS pipeline. Holds the
//             PC register and selects the next fetch address. In priority
//             order the sources are: reset, exception entry, eret return,
//             stall hold, D-stage branch/jump, and sequential PC+4. It also
//             flags fetch address errors (AdEL) and delay-slot membership
//             of the F-stage instruction for the exception path.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   clock, all state updates on posedge
//    reset          in   1   synchronous, active-high
//    i_stall        in   1   hazard stall, F and D hold
//    i_npcOp        in   3   D-stage next-PC select (PC4/BRANCH/J/JR)
//    i_D_pc         in   32  PC of the D-stage instruction
//    i_jumpEn_of_B  in   1   D-stage branch condition is true
//    i_imm16        in   16  branch offset in words
//    i_imm26        in   26  j/jal index
//    i_ra_of_jr     in   32  forwarded rs value for jr/jalr
//    i_exc_req      in   1   CP0 takes an exception/interrupt this cycle
//    i_eret         in   1   unstalled eret in D
//    i_epc          in   32  forwarded EPC value
//    o_F_pc         out  32  current fetch PC (IM address)
//    o_npc          out  32  value the PC register loads at the next edge
//    o_F_bd         out  1   F-stage instruction sits in a delay slot
//    o_F_adel       out  1   F-stage address misaligned or out of range
//    o_F_kill       out  1   turn the F-stage instruction into a nop in D
// ============================================================================
module f_pc_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
   parameter logic [31:0] IM_BASE    = 32'h0000_3000,
   parameter logic [31:0] IM_BYTES   = 32'h0000_4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_stall,
   input  logic [2:0]  i_npcOp,
   input  logic [31:0] i_D_pc,
   input  logic        i_jumpEn_of_B,
   input  logic [15:0] i_imm16,
   input  logic [25:0] i_imm26,
   input  logic [31:0] i_ra_of_jr,
   input  logic        i_exc_req,
   input  logic        i_eret,
   input  logic [31:0] i_epc,
   output logic [31:0] o_F_pc,
   output logic [31:0] o_npc,
   output logic        o_F_bd,
   output logic        o_F_adel,
   output logic        o_F_kill
);

   // Next-PC select encodings shared with the D-stage decoder.
   localparam logic [2:0] C_NPC_PC4    = 3'd0;
   localparam logic [2:0] C_NPC_BRANCH = 3'd1;
   localparam logic [2:0] C_NPC_J      = 3'd2;
   localparam logic [2:0] C_NPC_JR     = 3'd3;

   // Upper fetch bound widened to 33 bits so IM_BASE+IM_BYTES cannot wrap.
   localparam logic [32:0] C_IM_LO = {1'b0, IM_BASE};
   localparam logic [32:0] C_IM_HI = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_offset;
   logic [31:0] w_br_target;
   logic [31:0] w_j_target;
   logic        w_is_ctrl_op;
   logic        w_br_taken;
   logic [32:0] w_pc_wide;

   // ------------------------------------------------------------------------
   // Target arithmetic. Branch and jump targets come from the D-stage PC;
   // only the sequential path uses the fetch PC. All adds wrap modulo 2^32.
   // ------------------------------------------------------------------------
   assign w_pc_plus4  = pc_q + 32'd4;
   assign w_br_offset = {{14{i_imm16[15]}}, i_imm16, 2'b00};
   assign w_br_target = i_D_pc + 32'd4 + w_br_offset;
   assign w_j_target  = {i_D_pc[31:28], i_imm26, 2'b00};

   // Only the three legal control-transfer encodings count; anything else
   // is treated as plain sequential flow.
   assign w_is_ctrl_op = (i_npcOp == C_NPC_BRANCH) ||
                         (i_npcOp == C_NPC_J)      ||
                         (i_npcOp == C_NPC_JR);

   assign w_br_taken = (i_npcOp == C_NPC_BRANCH) && i_jumpEn_of_B;

   // ------------------------------------------------------------------------
   // Next-PC priority selection.
   // ------------------------------------------------------------------------
   always_comb begin
      pc_d     = w_pc_plus4;
      o_F_kill = 1'b0;
      if (i_exc_req) begin
         // Exception entry overrides everything, including a pending eret.
         pc_d = EXC_VECTOR;
      end else if (i_eret) begin
         // eret has no delay slot: the instruction already fetched behind
         // it must not execute.
         pc_d     = i_epc;
         o_F_kill = 1'b1;
      end else if (i_stall) begin
         // D is frozen, so its branch decision is not final yet.
         pc_d = pc_q;
      end else if (w_br_taken) begin
         pc_d = w_br_target;
      end else if (i_npcOp == C_NPC_J) begin
         pc_d = w_j_target;
      end else if (i_npcOp == C_NPC_JR) begin
         pc_d = i_ra_of_jr;
      end else begin
         pc_d = w_pc_plus4;
      end
   end

   // ------------------------------------------------------------------------
   // PC register.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // ------------------------------------------------------------------------
   // Status outputs.
   // ------------------------------------------------------------------------
   // The instruction being fetched follows a control transfer in D, so it is
   // a delay slot whether or not the branch is taken.
   assign o_F_bd = w_is_ctrl_op && !i_eret;

   assign w_pc_wide = {1'b0, pc_q};
   assign o_F_adel  = (pc_q[1:0] != 2'b00) ||
                      (w_pc_wide < C_IM_LO) ||
                      (w_pc_wide >= C_IM_HI);

   assign o_F_pc = pc_q;
   assign o_npc  = pc_d;

endmodule
`default_nettype wire

// File: tb/tb_f_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_f_pc_ctrl
//  Purpose  : Self-checking bench for f_pc_ctrl. A priority-rule model of
//             the fetch PC is compared against the DUT on every falling
//             edge; directed scenarios add hand-computed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_f_pc_ctrl;

   localparam logic [2:0] NPC_PC4    = 3'd0;
   localparam logic [2:0] NPC_BRANCH = 3'd1;
   localparam logic [2:0] NPC_J      = 3'd2;
   localparam logic [2:0] NPC_JR     = 3'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_stall;
   logic [2:0]  i_npcOp;
   logic [31:0] i_D_pc;
   logic        i_jumpEn_of_B;
   logic [15:0] i_imm16;
   logic [25:0] i_imm26;
   logic [31:0] i_ra_of_jr;
   logic        i_exc_req;
   logic        i_eret;
   logic [31:0] i_epc;
   logic [31:0] o_F_pc;
   logic [31:0] o_npc;
   logic        o_F_bd;
   logic        o_F_adel;
   logic        o_F_kill;

   int n_total = 0;
   int n_pass  = 0;

   f_pc_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .i_stall       (i_stall),
      .i_npcOp       (i_npcOp),
      .i_D_pc        (i_D_pc),
      .i_jumpEn_of_B (i_jumpEn_of_B),
      .i_imm16       (i_imm16),
      .i_imm26       (i_imm26),
      .i_ra_of_jr    (i_ra_of_jr),
      .i_exc_req     (i_exc_req),
      .i_eret        (i_eret),
      .i_epc         (i_epc),
      .o_F_pc        (o_F_pc),
      .o_npc         (o_npc),
      .o_F_bd        (o_F_bd),
      .o_F_adel      (o_F_adel),
      .o_F_kill      (o_F_kill)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   logic [31:0] m_pc;
   bit          m_valid = 0;

   function automatic logic [31:0] m_next(input logic [31:0] pc);
      int signed off;
      off = 32'(signed'(i_imm16)) * 4;
      if (i_exc_req)                                return 32'h0000_4180;
      if (i_eret)                                   return i_epc;
      if (i_stall)                                  return pc;
      if (i_npcOp == NPC_BRANCH && i_jumpEn_of_B)   return i_D_pc + 32'd4 + 32'(off);
      if (i_npcOp == NPC_J)                         return (i_D_pc & 32'hF000_0000) | (32'(i_imm26) * 4);
      if (i_npcOp == NPC_JR)                        return i_ra_of_jr;
      return pc + 32'd4;
   endfunction

   function automatic logic m_adel(input logic [31:0] pc);
      longint unsigned a;
      a = longint'(pc);
      return (pc % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 64'h4000);
   endfunction

   function automatic logic m_bd();
      return (i_npcOp >= 3'd1 && i_npcOp <= 3'd3) && !i_eret;
   endfunction

   function automatic logic m_kill();
      return i_eret && !i_exc_req;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_pc    <= 32'h0000_3000;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         m_pc <= m_next(m_pc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid && !reset) begin
         chk("model F_pc", o_F_pc, m_pc);
         chk("model npc",  o_npc,  m_next(m_pc));
         chk("model bd",   32'(o_F_bd),   32'(m_bd()));
         chk("model adel", 32'(o_F_adel), 32'(m_adel(m_pc)));
         chk("model kill", 32'(o_F_kill), 32'(m_kill()));
      end
   end

   // ---------------- stimulus ----------------
   task automatic defaults();
      i_stall = 0; i_npcOp = NPC_PC4; i_D_pc = 32'h0; i_jumpEn_of_B = 0;
      i_imm16 = 16'h0; i_imm26 = 26'h0; i_ra_of_jr = 32'h0;
      i_exc_req = 0; i_eret = 0; i_epc = 32'h0;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   // Redirect the fetch PC with a jr; afterwards F_pc == addr.
   task automatic goto_pc(input logic [31:0] addr);
      defaults();
      i_npcOp = NPC_JR; i_ra_of_jr = addr;
      cyc();
      defaults();
   endtask

   initial begin
      defaults();
      reset = 1;
      @(posedge clk); #1;
      i_exc_req = 1;               // reset must dominate
      cyc();
      reset = 0; i_exc_req = 0;

      // Reset release and sequential fetch.
      @(negedge clk); chk("reset pc",  o_F_pc, 32'h3000);
      cyc(); @(negedge clk); chk("seq1", o_F_pc, 32'h3004);
      cyc(); @(negedge clk); chk("seq2", o_F_pc, 32'h3008);
      cyc(); @(negedge clk); chk("seq3", o_F_pc, 32'h300C);

      // Taken and untaken branch.
      goto_pc(32'h3008);
      i_D_pc = 32'h3004; i_npcOp = NPC_BRANCH; i_jumpEn_of_B = 1; i_imm16 = 16'h0003;
      @(negedge clk);
      chk("br taken npc", o_npc, 32'h3014);
      chk("br taken bd",  32'(o_F_bd), 32'd1);
      #1 i_jumpEn_of_B = 0;
      #1 chk("br untaken npc", o_npc, 32'h300C);
      chk("br untaken bd", 32'(o_F_bd), 32'd1);
      #1 i_D_pc = 32'h3010; i_imm16 = 16'hFFFE; i_jumpEn_of_B = 1;
      #1 chk("br neg npc", o_npc, 32'h300C);
      cyc(); @(negedge clk); chk("br neg F_pc", o_F_pc, 32'h300C);

      // j
      defaults();
      i_npcOp = NPC_J; i_imm26 = 26'h0000C10; i_D_pc = 32'h3020;
      @(negedge clk); chk("j npc", o_npc, 32'h3040);
      cyc();

      // Stall over jr.
      goto_pc(32'h3008);
      i_stall = 1; i_npcOp = NPC_JR; i_ra_of_jr = 32'h3100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); chk("stall hold", o_F_pc, 32'h3008);
         cyc();
      end
      i_stall = 0;
      @(negedge clk); chk("stall release npc", o_npc, 32'h3100);
      cyc(); @(negedge clk); chk("jr landed", o_F_pc, 32'h3100);

      // Exception with stall and a taken branch.
      defaults();
      i_exc_req = 1; i_stall = 1; i_npcOp = NPC_BRANCH; i_jumpEn_of_B = 1;
      i_D_pc = 32'h3100; i_imm16 = 16'h0010;
      @(negedge clk); chk("exc npc", o_npc, 32'h4180);
      cyc(); @(negedge clk); chk("exc F_pc", o_F_pc, 32'h4180);

      // eret (with a branch op in D to exercise bd masking).
      defaults();
      i_eret = 1; i_epc = 32'h3024; i_npcOp = NPC_BRANCH;
      @(negedge clk);
      chk("eret npc",  o_npc, 32'h3024);
      chk("eret kill", 32'(o_F_kill), 32'd1);
      chk("eret bd",   32'(o_F_bd), 32'd0);
      #1 i_exc_req = 1;
      #1 chk("exc+eret npc", o_npc, 32'h4180);
      chk("exc+eret kill", 32'(o_F_kill), 32'd0);
      #1 i_exc_req = 0; i_stall = 1;
      #1 chk("stall+eret npc", o_npc, 32'h3024);
      cyc(); @(negedge clk); chk("eret F_pc", o_F_pc, 32'h3024);

      // AdEL boundaries.
      goto_pc(32'h3002); @(negedge clk); chk("adel misalign", 32'(o_F_adel), 32'd1);
      goto_pc(32'h2FFC); @(negedge clk); chk("adel low",      32'(o_F_adel), 32'd1);
      goto_pc(32'h7000); @(negedge clk); chk("adel high",     32'(o_F_adel), 32'd1);
      goto_pc(32'h6FFC); @(negedge clk); chk("adel top ok",   32'(o_F_adel), 32'd0);
      goto_pc(32'h3000); @(negedge clk); chk("adel base ok",  32'(o_F_adel), 32'd0);

      // Wraparound of the sequential add.
      goto_pc(32'hFFFF_FFFC);
      @(negedge clk); chk("wrap npc", o_npc, 32'h0);
      cyc(); @(negedge clk);
      chk("wrap F_pc", o_F_pc, 32'h0);
      chk("wrap adel", 32'(o_F_adel), 32'd1);

      // Illegal encoding behaves as sequential.
      goto_pc(32'h3200);
      i_npcOp = 3'd6; i_ra_of_jr = 32'h3300; i_jumpEn_of_B = 1; i_imm16 = 16'h0040;
      @(negedge clk); chk("illegal op npc", o_npc, 32'h3204);
      cyc();

      // Reset mid-run dominates an exception request.
      defaults();
      reset = 1; i_exc_req = 1;
      cyc();
      reset = 0; i_exc_req = 0;
      @(negedge clk); chk("reset over exc", o_F_pc, 32'h3000);
      cyc(); cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
